// File: rtl/input_sr_pkg.sv
// input_sr_pkg: shared state enum, default parameters and counter-width helper for input_sr.
package input_sr_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 64;
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction
endpackage

// File: rtl/input_sr_if.sv
// input_sr_if: valid/ready parallel word port of the serial receiver.
interface input_sr_if import input_sr_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/input_sr_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchroniser for a strobe plus W data bits, with strobe rising-edge detect.
module sync_edge #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_strobe,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_rise
);
  logic [STAGES-1:0][W:0] r_sync;
  logic                   r_prev;
  logic [STAGES:0]        r_vld;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], {i_data, i_strobe}};
      r_prev <= r_sync[STAGES-1][0];
      r_vld  <= {r_vld[STAGES-1:0], 1'b1};
    end
  assign o_data = r_sync[STAGES-1][W:1];
  // r_vld masks edges until the chain holds real samples, so a strobe high at reset release is not an edge
  assign o_rise = r_sync[STAGES-1][0] & ~r_prev & r_vld[STAGES];
endmodule

// File: rtl/input_sr.sv
// input_sr: serial-to-parallel receiver, MSB-first, valid/ready output.
// Define INPUT_SR_TIMEOUT_EN to discard partial words after TIMEOUT idle cycles.
module input_sr import input_sr_pkg::*; #(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_sdata,
  input_sr_if.master        m_if,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_frame_err
);
  localparam int CW = cnt_w(DATA_W);
  logic              w_rise;
  logic              w_bit;
  logic              w_last;
  logic              w_tmo;
  logic              w_load;
  logic              w_drop;
  logic [DATA_W-1:0] w_word;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-2:0] r_shreg;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ovr;
  sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_strobe (i_sclk),
    .i_data   (i_sdata),
    .o_data   (w_bit),
    .o_rise   (w_rise)
  );
  assign w_word = {r_shreg, w_bit};
  assign w_last = w_rise && r_cnt == CW'(DATA_W - 1);
  assign w_load = w_last && (!r_valid || m_if.ready);
  assign w_drop = w_last && r_valid && !m_if.ready;
  always_comb
    w_state_nxt = (w_last || w_tmo) ? IDLE : w_rise ? SHIFT : r_state;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_rise) begin
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      r_shreg <= w_last ? '0 : w_word[DATA_W-2:0];
    end else if (w_tmo) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end
  // A completed word is written straight from the shifter so output latency stays SYNC_STAGES edges
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && m_if.ready)
        r_valid <= 1'b0;
      r_ovr <= w_drop;
    end
`ifdef INPUT_SR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_ferr;
  assign w_tmo = r_state == SHIFT && !w_rise && r_tmo == TW'(TIMEOUT - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tmo  <= '0;
      r_ferr <= 1'b0;
    end else begin
      r_tmo  <= (r_state != SHIFT || w_rise || w_tmo) ? '0 : r_tmo + 1'b1;
      r_ferr <= w_tmo;
    end
  assign o_frame_err = r_ferr;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = TIMEOUT > 0;
  assign w_tmo        = 1'b0;
  assign o_frame_err  = 1'b0;
`endif
  assign m_if.data  = r_data;
  assign m_if.valid = r_valid;
  assign o_busy     = r_cnt != '0;
  assign o_overrun  = r_ovr;
endmodule

// File: doc/input_sr.md
# input_sr

Serial-to-parallel receiver paired with the team's output shift register. It samples a serial bit line and its strobe clock, which are asynchronous to the local clock, and synchronises both. Each word is assembled MSB-first and presented on a valid/ready parallel port. It sits at the receive end of the chip-to-chip serial link, so a bench can loop the transmitter's serial outputs straight into it.

## Interface
Parameters:
- DATA_W, 8: word width in bits.
- SYNC_STAGES, 2: synchroniser depth on i_sclk and i_sdata. Minimum 2.
- TIMEOUT, 64: number of i_clk cycles with no strobe edge, mid-word, before the partial word is discarded.

Ports:
- i_clk  in  1  system clock. All logic runs on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_sclk  in  1  serial strobe. Data is captured on its rising edge. Asynchronous to i_clk.
- i_sdata  in  1  serial data bit. Asynchronous to i_clk.
- o_data  out  DATA_W  received word. Valid while o_valid is high.
- o_valid  out  1  word available.
- i_ready  in  1  consumer accepts o_data when o_valid and i_ready are both high at a rising edge of i_clk.
- o_busy  out  1  a word is partially received (bit count is not 0).
- o_overrun  out  1  one-cycle pulse: a completed word was dropped.
- o_frame_err  out  1  one-cycle pulse: a partial word was discarded on timeout. Stays 0 when the timeout feature is compiled out.

## Operation
- Synchroniser:
  - i_sclk and i_sdata each pass through SYNC_STAGES flops, so both lines see equal delay.
  - A rising-edge detector compares the synchronised strobe with its previous value.
- Shift behaviour: on each detected strobe edge, the synchronised data bit shifts into the LSB of the shift register (MSB-first order), and the bit counter increments.
- Two-state FSM:
  - IDLE: bit count is 0. A strobe edge moves the FSM to SHIFT.
  - SHIFT: strobe edges accumulate bits. When the DATA_W-th bit is captured, the word completes, the counter goes to 0 and the FSM returns to IDLE.
- Word completion:
  - If the output buffer is empty, or is being accepted in the same cycle: the new word loads into o_data and o_valid is 1 next cycle.
  - If the output buffer is full and i_ready is 0: the new word is dropped, o_data is unchanged, and o_overrun pulses.
- Output buffer: o_valid holds until it is accepted. An accept with no new word clears o_valid.
- Strobe edge in the timeout cycle: the edge wins, the timeout does not fire and the bit is counted.
- Reset, including mid-word, asynchronously forces:
  - every output to 0, including o_data;
  - the shift register and all counters to 0;
  - all synchroniser flops to 0;
  - the FSM to IDLE.
- Strobe high when reset releases: this is not an edge. The first edge requires a low-to-high transition seen after reset.

## Timing
- Strobe phases: i_sclk high and low must each last at least SYNC_STAGES+1 i_clk cycles.
- Data window: i_sdata must be stable from 1 cycle before to SYNC_STAGES cycles after the i_sclk rise.
- Latency:
  - Let N be the first i_clk edge that samples the final bit's i_sclk high.
  - The edge is detected at N+SYNC_STAGES−1.
  - o_valid and o_data update at edge N+SYNC_STAGES.
- o_busy rises one cycle after the first bit's detected edge and falls together with o_valid rising.
- Throughput: one word per DATA_W strobe periods. There are no dead cycles between words.
- Pulse timing: o_overrun and o_frame_err are registered and last exactly one cycle.

## Configuration
- INPUT_SR_TIMEOUT_EN defined:
  - The timeout counter counts i_clk cycles in SHIFT and clears on every strobe edge.
  - When it reaches TIMEOUT, the bit counter and shift register clear, the FSM goes to IDLE and o_frame_err pulses.
  - o_valid and o_data are not affected.
- Undefined: there is no timeout counter, o_frame_err is tied to 0, and a partial word waits for further edges indefinitely.

## Structure
- Shared package input_sr_pkg holds:
  - the state enum (IDLE, SHIFT);
  - default constants for DATA_W, SYNC_STAGES and TIMEOUT;
  - the bit-counter width function, clog2(DATA_W+1).
- Sub-module sync_edge holds the parameterised SYNC_STAGES synchroniser plus the rising-edge detector. It is instantiated once for the strobe. The data line uses the same sync chain with the detector disabled, or a second instance with the edge output unused.

## Test plan
- Back-to-back words 0x01, 0x80, 0x00, 0xFF, 0xAA, i_ready=1, 4-cycle strobe phases:
  - each o_valid pulse carries the matching byte, MSB-first;
  - o_overrun and o_frame_err stay 0.
- Word 0x5A, i_ready=0, then word 0x3C, still i_ready=0:
  - o_data stays 0x5A;
  - o_overrun pulses once, SYNC_STAGES cycles after the 0x3C final edge is sampled;
  - raising i_ready then clears o_valid.
- i_ready raised in the exact cycle that word 0xC3 completes with 0x11 held: 0x11 is accepted, o_data becomes 0xC3, o_valid stays 1, no overrun.
- With INPUT_SR_TIMEOUT_EN: send 3 bits, idle 64+ cycles, then send full word 0xE7:
  - o_frame_err pulses once;
  - o_valid shows 0xE7, not a mixed word.
- i_rst_n asserted after 5 bits of 0xF0:
  - all outputs are 0 immediately, o_busy=0;
  - a following full word 0x96 is received correctly.
- i_sclk held high through reset release then lowered: no bit is counted; the next rise counts as bit 1.
